// File: rtl/bcd_tick_counter.sv
// Multi-digit BCD up/down counter advanced by rising edges of a slow, asynchronous tick.
// Optional macro SEVEN_SEG_EN adds o_hex, registered active-low seven-segment patterns per digit.
module bcd_tick_counter #(
  parameter int Digits = 4
) (
  input  logic                  i_clock_50mhz,
  input  logic                  i_reset,
  input  logic                  i_tick,
  input  logic                  i_start,
  input  logic                  i_stop,
  input  logic                  i_clear,
  input  logic                  i_up,
  input  logic                  i_load,
  input  logic [4*Digits-1:0]   i_load_value,
  output logic [4*Digits-1:0]   o_count,
  output logic                  o_running,
  output logic                  o_wrap
`ifdef SEVEN_SEG_EN
  ,
  output logic [7*Digits-1:0]   o_hex
`endif
);

  localparam int W = 4 * Digits;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] PAUSED = 2'd2;

  logic          s1_reg, s2_reg, s3_reg;
  logic          tick;
  logic [1:0]    state_reg, state_next;
  logic [W-1:0]  count_reg, count_next;
  logic [W-1:0]  step_value, load_clamped;
  logic [Digits:0] chain;
  logic          wrap_reg, wrap_next;
  logic          running_reg;

  assign tick = s2_reg & ~s3_reg;

  // chain[i] is the carry (up) or borrow (down) entering digit i
  assign chain[0] = 1'b1;

  generate
    for (genvar gi = 0; gi < Digits; gi++) begin : g_digit
      logic [3:0] digit;
      logic [3:0] load_nibble;

      assign digit       = count_reg[4*gi +: 4];
      assign load_nibble = i_load_value[4*gi +: 4];

      assign chain[gi+1] = chain[gi] & (i_up ? (digit == 4'd9) : (digit == 4'd0));

      always_comb begin
        step_value[4*gi +: 4] = digit;
        if (chain[gi]) begin
          if (i_up)
            step_value[4*gi +: 4] = (digit == 4'd9) ? 4'd0 : digit + 4'd1;
          else
            step_value[4*gi +: 4] = (digit == 4'd0) ? 4'd9 : digit - 4'd1;
        end
      end

      assign load_clamped[4*gi +: 4] = (load_nibble > 4'd9) ? 4'd9 : load_nibble;
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    wrap_next  = 1'b0;
    if (i_clear) begin
      state_next = IDLE;
      count_next = '0;
    end else if (i_load) begin
      count_next = load_clamped;
    end else if (i_stop && state_reg == RUN) begin
      state_next = PAUSED;
    end else if (i_start && state_reg != RUN) begin
      state_next = RUN;
    end else if (tick && state_reg == RUN) begin
      count_next = step_value;
      wrap_next  = chain[Digits];
    end
  end

  always_ff @(posedge i_clock_50mhz or negedge i_reset) begin
    if (!i_reset) begin
      s1_reg      <= 1'b0;
      s2_reg      <= 1'b0;
      s3_reg      <= 1'b0;
      state_reg   <= IDLE;
      count_reg   <= '0;
      wrap_reg    <= 1'b0;
      running_reg <= 1'b0;
    end else begin
      s1_reg      <= i_tick;
      s2_reg      <= s1_reg;
      s3_reg      <= s2_reg;
      state_reg   <= state_next;
      count_reg   <= count_next;
      wrap_reg    <= wrap_next;
      running_reg <= (state_next == RUN);
    end
  end

  assign o_count   = count_reg;
  assign o_running = running_reg;
  assign o_wrap    = wrap_reg;

`ifdef SEVEN_SEG_EN
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  generate
    for (genvar gi = 0; gi < Digits; gi++) begin : g_seg
      logic [6:0] seg_reg;
      always_ff @(posedge i_clock_50mhz or negedge i_reset) begin
        if (!i_reset)
          seg_reg <= 7'b1000000;
        else
          seg_reg <= seg7(count_reg[4*gi +: 4]);
      end
      assign o_hex[7*gi +: 7] = seg_reg;
    end
  endgenerate
`endif

endmodule

// File: tb/tb_bcd_tick_counter.sv
// Bench for bcd_tick_counter: directed test-plan steps then random stimulus against a decimal model.
// Set SEVEN_SEG_EN to also check o_hex.
module tb_bcd_tick_counter;

  localparam int Digits = 4;
  localparam int W      = 4 * Digits;
  localparam int MOD    = 10000;

  logic          i_clock_50mhz = 1'b0;
  logic          i_reset = 1'b0;
  logic          i_tick = 1'b0, i_start = 1'b0, i_stop = 1'b0, i_clear = 1'b0;
  logic          i_up = 1'b1, i_load = 1'b0;
  logic [W-1:0]  i_load_value = '0;
  logic [W-1:0]  o_count;
  logic          o_running, o_wrap;
`ifdef SEVEN_SEG_EN
  logic [7*Digits-1:0] o_hex;
`endif

  bcd_tick_counter #(.Digits(Digits)) dut (
    .i_clock_50mhz (i_clock_50mhz),
    .i_reset       (i_reset),
    .i_tick        (i_tick),
    .i_start       (i_start),
    .i_stop        (i_stop),
    .i_clear       (i_clear),
    .i_up          (i_up),
    .i_load        (i_load),
    .i_load_value  (i_load_value),
    .o_count       (o_count),
    .o_running     (o_running),
    .o_wrap        (o_wrap)
`ifdef SEVEN_SEG_EN
    ,
    .o_hex         (o_hex)
`endif
  );

  always #10 i_clock_50mhz = ~i_clock_50mhz;

  int vectors = 0;
  int miscompares = 0;
  int wrap_cnt = 0;

  // Reference model: count as a plain decimal integer
  int   m_val = 0;
  int   m_state = 0;   // 0 idle, 1 run, 2 paused
  bit   m_wrap = 1'b0;
  bit   h1 = 1'b0, h2 = 1'b0, h3 = 1'b0;  // i_tick as sampled 1, 2, 3 edges ago
  logic [7*Digits-1:0] m_hex;

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < Digits; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic int load_to_int(input logic [W-1:0] lv);
    int acc, scale, nib;
    acc = 0;
    scale = 1;
    for (int i = 0; i < Digits; i++) begin
      nib = int'(lv[4*i +: 4]);
      acc += ((nib > 9) ? 9 : nib) * scale;
      scale *= 10;
    end
    return acc;
  endfunction

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;  1: return 7'b1111001;  2: return 7'b0100100;
      3: return 7'b0110000;  4: return 7'b0011001;  5: return 7'b0010010;
      6: return 7'b0000010;  7: return 7'b1111000;  8: return 7'b0000000;
      default: return 7'b0010000;
    endcase
  endfunction

  function automatic logic [7*Digits-1:0] hex_of(input int v);
    logic [7*Digits-1:0] r;
    int x;
    x = v;
    for (int i = 0; i < Digits; i++) begin
      r[7*i +: 7] = seg_of(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic model_reset();
    m_val = 0; m_state = 0; m_wrap = 1'b0;
    h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
    m_hex = hex_of(0);
  endtask

  task automatic model_edge();
    bit ev;
    if (!i_reset) begin
      model_reset();
      return;
    end
    ev = h2 & ~h3;
    h3 = h2; h2 = h1; h1 = i_tick;
    m_hex  = hex_of(m_val);
    m_wrap = 1'b0;
    if (i_clear) begin
      m_state = 0; m_val = 0;
    end else if (i_load) begin
      m_val = load_to_int(i_load_value);
    end else if (i_stop && m_state == 1) begin
      m_state = 2;
    end else if (i_start && m_state != 1) begin
      m_state = 1;
    end else if (ev && m_state == 1) begin
      if (i_up) begin
        m_wrap = (m_val == MOD - 1);
        m_val  = (m_val + 1) % MOD;
      end else begin
        m_wrap = (m_val == 0);
        m_val  = (m_val + MOD - 1) % MOD;
      end
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("count", 64'(o_count), 64'(to_bcd(m_val)));
    check("running", 64'(o_running), 64'(m_state == 1));
    check("wrap", 64'(o_wrap), 64'(m_wrap));
`ifdef SEVEN_SEG_EN
    check("hex", 64'(o_hex), 64'(m_hex));
`endif
  endtask

  task automatic cyc();
    @(posedge i_clock_50mhz);
    model_edge();
    @(negedge i_clock_50mhz);
    if (o_wrap === 1'b1) wrap_cnt++;
    check_all();
  endtask

  task automatic pulse_tick();
    i_tick = 1'b1;
    repeat (4) cyc();
    i_tick = 1'b0;
    repeat (4) cyc();
  endtask

  task automatic do_load(input logic [W-1:0] v);
    i_load = 1'b1; i_load_value = v;
    cyc();
    i_load = 1'b0;
  endtask

  initial begin
    model_reset();
    // Reset state
    repeat (2) cyc();
    check("reset_count", 64'(o_count), 64'h0);
    check("reset_running", 64'(o_running), 64'h0);
    @(negedge i_clock_50mhz);
    i_reset = 1'b1;

    // Start and three up ticks
    i_start = 1'b1; cyc(); i_start = 1'b0;
    repeat (3) pulse_tick();
    check("three_ticks", 64'(o_count), 64'h0003);
    check("running_after_start", 64'(o_running), 64'h1);

    // Up wrap from 9999
    do_load(16'h9998);
    pulse_tick();
    check("to_9999", 64'(o_count), 64'h9999);
    wrap_cnt = 0;
    pulse_tick();
    check("up_wrap_count", 64'(o_count), 64'h0000);
    check("up_wrap_pulses", 64'(wrap_cnt), 64'h1);

    // Down wrap from 0000
    i_up = 1'b0; wrap_cnt = 0;
    pulse_tick();
    check("down_wrap_count", 64'(o_count), 64'h9999);
    check("down_wrap_pulses", 64'(wrap_cnt), 64'h1);

    // Load clamp
    do_load(16'h1A2F);
    check("load_clamp", 64'(o_count), 64'h1929);

    // Stop holds count, start resumes
    i_up = 1'b1;
    do_load(16'h0042);
    i_stop = 1'b1; cyc(); i_stop = 1'b0;
    check("paused_running", 64'(o_running), 64'h0);
    repeat (2) pulse_tick();
    check("paused_hold", 64'(o_count), 64'h0042);
    i_start = 1'b1; cyc(); i_start = 1'b0;
    pulse_tick();
    check("resume", 64'(o_count), 64'h0043);

    // Tick and load in the same cycle: load wins
    i_tick = 1'b1;
    cyc(); cyc();
    i_load = 1'b1; i_load_value = 16'h0500;
    cyc();
    i_load = 1'b0; i_tick = 1'b0;
    repeat (3) cyc();
    check("load_beats_tick", 64'(o_count), 64'h0500);

    // Asynchronous reset mid-run
    pulse_tick();
    i_reset = 1'b0;
    #1;
    check("async_reset_count", 64'(o_count), 64'h0);
    check("async_reset_running", 64'(o_running), 64'h0);
    check("async_reset_wrap", 64'(o_wrap), 64'h0);
`ifdef SEVEN_SEG_EN
    check("async_reset_hex0", 64'(o_hex[6:0]), 64'h40);
`endif
    model_reset();
    repeat (2) cyc();
    @(negedge i_clock_50mhz);
    i_reset = 1'b1;

    // Randomised phase
    for (int n = 0; n < 3000; n++) begin
      int r;
      if ($urandom_range(0, 3) == 0) i_tick = ~i_tick;
      if ($urandom_range(0, 15) == 0) i_up = ~i_up;
      i_clear = ($urandom_range(0, 63) == 0);
      i_load  = ($urandom_range(0, 31) == 0);
      i_stop  = ($urandom_range(0, 15) == 0);
      i_start = ($urandom_range(0, 7) == 0);
      r = int'($urandom_range(0, 3));
      case (r)
        0: i_load_value = 16'h9999;
        1: i_load_value = 16'h0000;
        2: i_load_value = 16'h9998;
        default: i_load_value = 16'($urandom);
      endcase
      if ($urandom_range(0, 499) == 0) begin
        i_tick = 1'b0;
        i_reset = 1'b0;
        #1;
        check("rand_reset_count", 64'(o_count), 64'h0);
        model_reset();
        cyc();
        @(negedge i_clock_50mhz);
        i_reset = 1'b1;
      end
      cyc();
    end
    i_clear = 1'b0; i_load = 1'b0; i_stop = 1'b0; i_start = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
